// File: rtl/timepulse_monitor_if.sv
// Monitor-side bundle between the timer's MT/MGOJAM outputs and the time-pulse monitor.
// The master drives the pulses and the error clear. The slave reports sequence state and counters.
interface timepulse_monitor_if #(
    parameter int COUNT_W = 16
);
    logic [11:0]        MT;
    logic               MGOJAM;
    logic               CLR_ERR;
    logic [3:0]         TP_NUM;
    logic               TP_STROBE;
    logic               MCT_DONE;
    logic [COUNT_W-1:0] MCT_COUNT;
    logic [COUNT_W-1:0] GOJAM_COUNT;
    logic               IN_SYNC;
    logic               STOPPED;
    logic               SEQ_ERR;
    logic [1:0]         ERR_CODE;

    modport master (
        output MT, MGOJAM, CLR_ERR,
        input  TP_NUM, TP_STROBE, MCT_DONE, MCT_COUNT, GOJAM_COUNT,
               IN_SYNC, STOPPED, SEQ_ERR, ERR_CODE
    );

    modport slave (
        input  MT, MGOJAM, CLR_ERR,
        output TP_NUM, TP_STROBE, MCT_DONE, MCT_COUNT, GOJAM_COUNT,
               IN_SYNC, STOPPED, SEQ_ERR, ERR_CODE
    );
endinterface

// File: rtl/timepulse_monitor.sv
// Rebuilds the current time-pulse number from MT01..MT12 and counts completed MCTs and GOJAMs.
// It also flags sequence and encoding faults and detects a stopped timer.
module timepulse_monitor #(
    parameter int FILTER       = 2,
    parameter int STALL_CYCLES = 64,
    parameter int COUNT_W      = 16
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    timepulse_monitor_if.slave mon
);
    localparam int FW = $clog2(FILTER + 2);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [FW-1:0] FILT_V   = FW'(FILTER);
    localparam logic [FW-1:0] FILT_SAT = FW'(FILTER + 1);
    localparam logic [SW-1:0] STALL_V  = SW'(STALL_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SYNC, S_STALL} state_t;

    state_t             state_q, state_d;
    logic [11:0]        mt_q, mt_d;
    logic               gj_q, gj_d, gj_dly_q, gj_dly_d;
    logic [FW-1:0]      same_q, same_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic [3:0]         exp_q, exp_d;
    logic [3:0]         tp_q, tp_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] mct_q, mct_d;
    logic [COUNT_W-1:0] gjcnt_q, gjcnt_d;
    logic               serr_q, serr_d;
    logic [1:0]         ecode_q, ecode_d;
    logic               act, hit, err_set;
    logic [1:0]         err_val;

    function automatic logic is_onehot(input logic [11:0] c);
        return (c != 12'd0) && ((c & (c - 12'd1)) == 12'd0);
    endfunction

    function automatic logic [3:0] tp_index(input logic [11:0] c);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (c[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    always_comb begin
        state_d  = state_q;
        mt_d     = mon.MT;
        gj_d     = mon.MGOJAM;
        gj_dly_d = gj_q;
        same_d   = same_q;
        stall_d  = stall_q;
        exp_d    = exp_q;
        tp_d     = tp_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        mct_d    = mct_q;
        gjcnt_d  = gjcnt_q;
        serr_d   = serr_q;
        ecode_d  = ecode_q;
        err_set  = 1'b0;
        err_val  = 2'b00;

        // The filter count saturates one past FILTER, so each stable code fires exactly once.
        if (mon.MT != mt_q) begin
            same_d = FW'(1);
        end else if (same_q != FILT_SAT) begin
            same_d = same_q + FW'(1);
        end
        act = (same_q == FILT_V) && (mt_q != 12'd0);
        hit = act && is_onehot(mt_q) && (tp_index(mt_q) == exp_q);

        if (gj_q && !gj_dly_q) gjcnt_d = gjcnt_q + COUNT_W'(1);

        if ((state_q == S_RUN) || (state_q == S_STALL)) begin
            stall_d = (stall_q == STALL_V) ? stall_q : stall_q + SW'(1);
        end

        if (gj_q) begin
            state_d = S_IDLE;
            tp_d    = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_SYNC: begin
                    if (act && (mt_q == 12'h001)) begin
                        state_d  = S_RUN;
                        tp_d     = 4'd1;
                        strobe_d = 1'b1;
                        exp_d    = 4'd2;
                        stall_d  = '0;
                    end
                end
                default: begin
                    if (hit) begin
                        state_d  = S_RUN;
                        tp_d     = exp_q;
                        strobe_d = 1'b1;
                        stall_d  = '0;
                        if (exp_q == 4'd12) begin
                            done_d = 1'b1;
                            mct_d  = mct_q + COUNT_W'(1);
                            exp_d  = 4'd1;
                        end else begin
                            exp_d = exp_q + 4'd1;
                        end
                    end else if (act) begin
                        err_set = 1'b1;
                        err_val = (state_q == S_STALL) ? 2'b11 :
                                  is_onehot(mt_q)      ? 2'b01 : 2'b10;
                        tp_d    = 4'd0;
                        state_d = S_SYNC;
                    end else if ((state_q == S_RUN) && (stall_d == STALL_V)) begin
                        state_d = S_STALL;
                    end
                end
            endcase
        end

        // A fault on the same edge as CLR_ERR must survive the clear.
        if (err_set) begin
            serr_d  = 1'b1;
            ecode_d = err_val;
        end else if (mon.CLR_ERR) begin
            serr_d  = 1'b0;
            ecode_d = 2'b00;
        end
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q  <= S_IDLE;
            mt_q     <= '0;
            gj_q     <= 1'b0;
            gj_dly_q <= 1'b0;
            same_q   <= '0;
            stall_q  <= '0;
            exp_q    <= 4'd1;
            tp_q     <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            mct_q    <= '0;
            gjcnt_q  <= '0;
            serr_q   <= 1'b0;
            ecode_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            gj_q     <= gj_d;
            gj_dly_q <= gj_dly_d;
            same_q   <= same_d;
            stall_q  <= stall_d;
            exp_q    <= exp_d;
            tp_q     <= tp_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            mct_q    <= mct_d;
            gjcnt_q  <= gjcnt_d;
            serr_q   <= serr_d;
            ecode_q  <= ecode_d;
        end
    end

    assign mon.TP_NUM      = tp_q;
    assign mon.TP_STROBE   = strobe_q;
    assign mon.MCT_DONE    = done_q;
    assign mon.MCT_COUNT   = mct_q;
    assign mon.GOJAM_COUNT = gjcnt_q;
    assign mon.IN_SYNC     = (state_q == S_RUN) || (state_q == S_STALL);
    assign mon.STOPPED     = (state_q == S_STALL);
    assign mon.SEQ_ERR     = serr_q;
    assign mon.ERR_CODE    = ecode_q;
endmodule
